// File: rtl/wait_gate_loader_pkg.sv
// rtl/wait_gate_loader_pkg.sv - shared state encoding and counter sizing for wait_gate_loader
package wait_gate_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_EN = 3'd1,
    ST_DLY_A   = 3'd2,
    ST_DLY_C   = 3'd3,
    ST_DONE    = 3'd4
  } wgl_state_e;

  // One down-counter is shared by the timeout wait and both delays, so size it for the largest.
  function automatic int wgl_cnt_width(input int dly_a, input int dly_c, input int tmo);
    int m;
    m = dly_a;
    if (dly_c > m) m = dly_c;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wait_gate_loader_ch.sv
// rtl/wait_gate_loader_ch.sv - one channel: arm, level-gated wait, then two delayed captures
// WGL_TIMEOUT_EN adds a bounded WAIT_EN and the timeout flag.
module wait_gate_loader_ch
  import wait_gate_loader_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DLY_A   = 10,
  parameter int DLY_C   = 10,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_c,
  output logic [WIDTH-1:0] dout_a,
  output logic [WIDTH-1:0] dout_c,
  output logic             valid_a,
  output logic             valid_c,
  output logic             busy
`ifdef WGL_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam int CW = wgl_cnt_width(DLY_A, DLY_C, TIMEOUT);
  localparam logic [CW-1:0] LOAD_A = CW'(DLY_A - 1);
  localparam logic [CW-1:0] LOAD_C = CW'(DLY_C - 1);

  if (DLY_A < 1) begin : g_bad_dly_a
    $error("wait_gate_loader_ch: DLY_A must be at least 1");
  end
  if (DLY_C < 1) begin : g_bad_dly_c
    $error("wait_gate_loader_ch: DLY_C must be at least 1");
  end

  wgl_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_a_q, dout_a_d;
  logic [WIDTH-1:0] dout_c_q, dout_c_d;
  logic             valid_a_q, valid_a_d;
  logic             valid_c_q, valid_c_d;
`ifdef WGL_TIMEOUT_EN
  localparam logic [CW-1:0] LOAD_TO = CW'(TIMEOUT - 1);
  logic             timeout_q, timeout_d;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wait_gate_loader_ch: TIMEOUT must be at least 1");
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_a_d  = dout_a_q;
    dout_c_d  = dout_c_q;
    valid_a_d = valid_a_q;
    valid_c_d = valid_c_q;
`ifdef WGL_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WAIT_EN;
          valid_a_d = 1'b0;
          valid_c_d = 1'b0;
`ifdef WGL_TIMEOUT_EN
          timeout_d = 1'b0;
          cnt_d     = LOAD_TO;
`else
          cnt_d     = '0;
`endif
        end
      end
      // Enable is a level: seeing it on expiry still starts the normal sequence.
      ST_WAIT_EN: begin
        if (enable) begin
          state_d = ST_DLY_A;
          cnt_d   = LOAD_A;
        end
`ifdef WGL_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end
      ST_DLY_A: begin
        if (cnt_q == '0) begin
          state_d   = ST_DLY_C;
          cnt_d     = LOAD_C;
          dout_a_d  = din_a;
          valid_a_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DLY_C: begin
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          dout_c_d  = din_c;
          valid_c_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dout_a_q  <= '0;
      dout_c_q  <= '0;
      valid_a_q <= 1'b0;
      valid_c_q <= 1'b0;
`ifdef WGL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_a_q  <= dout_a_d;
      dout_c_q  <= dout_c_d;
      valid_a_q <= valid_a_d;
      valid_c_q <= valid_c_d;
`ifdef WGL_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign dout_a  = dout_a_q;
  assign dout_c  = dout_c_q;
  assign valid_a = valid_a_q;
  assign valid_c = valid_c_q;
  assign busy    = (state_q == ST_WAIT_EN) || (state_q == ST_DLY_A) || (state_q == ST_DLY_C);
`ifdef WGL_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: rtl/wait_gate_loader.sv
// rtl/wait_gate_loader.sv - CHANNELS independent gated, delayed register loaders
// Define WGL_TIMEOUT_EN to add the per-channel timeout port.
module wait_gate_loader
  import wait_gate_loader_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DLY_A    = 10,
  parameter int DLY_C    = 10,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] din_a,
  input  logic [CHANNELS*WIDTH-1:0] din_c,
  output logic [CHANNELS*WIDTH-1:0] dout_a,
  output logic [CHANNELS*WIDTH-1:0] dout_c,
  output logic [CHANNELS-1:0]       valid_a,
  output logic [CHANNELS-1:0]       valid_c,
  output logic [CHANNELS-1:0]       busy
`ifdef WGL_TIMEOUT_EN
  ,
  output logic [CHANNELS-1:0]       timeout
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wait_gate_loader_ch #(
      .WIDTH  (WIDTH),
      .DLY_A  (DLY_A),
      .DLY_C  (DLY_C),
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .start  (start[i]),
      .enable (enable[i]),
      .din_a  (din_a[i*WIDTH +: WIDTH]),
      .din_c  (din_c[i*WIDTH +: WIDTH]),
      .dout_a (dout_a[i*WIDTH +: WIDTH]),
      .dout_c (dout_c[i*WIDTH +: WIDTH]),
      .valid_a(valid_a[i]),
      .valid_c(valid_c[i]),
      .busy   (busy[i])
`ifdef WGL_TIMEOUT_EN
      ,
      .timeout(timeout[i])
`endif
    );
  end

endmodule

// File: tb/tb_wait_gate_loader.sv
// tb/tb_wait_gate_loader.sv - scenario-table and capture-scoreboard bench for wait_gate_loader
// Timeout scenarios are added when WGL_TIMEOUT_EN is defined.
module tb_wait_gate_loader;

  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int TO  = 20;
  localparam int RUN = 56;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   start, enable;
  logic [NCH*W-1:0] din_a, din_c, dout_a, dout_c;
  logic [NCH-1:0]   valid_a, valid_c, busy;
`ifdef WGL_TIMEOUT_EN
  logic [NCH-1:0]   timeout;
`endif

  wait_gate_loader #(
    .WIDTH(W), .CHANNELS(NCH), .DLY_A(10), .DLY_C(10), .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .enable (enable),
    .din_a  (din_a),
    .din_c  (din_c),
    .dout_a (dout_a),
    .dout_c (dout_c),
    .valid_a(valid_a),
    .valid_c(valid_c),
    .busy   (busy)
`ifdef WGL_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  // One row per start pulse; ea/ec are the expected capture edges (-1: never).
  typedef struct {
    int scn; int ch; bit ign; int s; int ef; int et; int ea; int ec;
  } row_t;
  typedef struct packed {
    logic busy; logic va; logic vc; logic to; logic [W-1:0] da; logic [W-1:0] dc;
  } obs_t;
  typedef struct {
    int ch; int kind; int edge_n; logic [W-1:0] data;
  } sb_t;

  row_t       rows[$];
  sb_t        sbq[$];
  int         rst_tab[8];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cur_scn = 0;
  int         nscn = 0;
  logic [W-1:0] base_a [NCH];
  logic [W-1:0] base_c [NCH];
  logic         prev_va [NCH];
  logic         prev_vc [NCH];

  task automatic add_row(input int scn, input int ch, input int ign, input int s,
                         input int ef, input int et, input int ea, input int ec);
    row_t r;
    r.scn = scn; r.ch = ch; r.ign = (ign != 0); r.s = s;
    r.ef = ef; r.et = et; r.ea = ea; r.ec = ec;
    rows.push_back(r);
    if (scn + 1 > nscn) nscn = scn + 1;
  endtask

  task automatic check(input string name, input int e, input int ch,
                       input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s scn=%0d edge=%0d ch=%0d actual=%h required=%h",
               name, cur_scn, e, ch, act, req);
    end
  endtask

  function automatic logic [63:0] all_out();
    logic [63:0] v;
    v = 64'({dout_a, dout_c, valid_a, valid_c, busy});
`ifdef WGL_TIMEOUT_EN
    v[39:38] = timeout;
`endif
    return v;
  endfunction

  function automatic obs_t obs_dut(input int ch);
    obs_t o;
    o.busy = busy[ch];
    o.va   = valid_a[ch];
    o.vc   = valid_c[ch];
`ifdef WGL_TIMEOUT_EN
    o.to   = timeout[ch];
`else
    o.to   = 1'b0;
`endif
    o.da   = dout_a[ch*W +: W];
    o.dc   = dout_c[ch*W +: W];
    return o;
  endfunction

  // Expected channel outputs after edge e, from the scenario table alone.
  function automatic obs_t exp_ch(input int scn, input int ch, input int e);
    obs_t o;
    row_t lr;
    int best_s, best_a, best_c, end_b, r0;
    o = '0; best_s = -1; best_a = -1; best_c = -1; r0 = rst_tab[scn];
    for (int i = 0; i < rows.size(); i++) begin
      if (rows[i].scn != scn || rows[i].ch != ch || rows[i].ign || rows[i].s > e) continue;
      if (r0 >= 0 && e >= r0 && rows[i].s < r0 + 2) continue;
      if (rows[i].s > best_s) begin best_s = rows[i].s; lr = rows[i]; end
      if (rows[i].ea >= 0 && rows[i].ea <= e && rows[i].ea > best_a) best_a = rows[i].ea;
      if (rows[i].ec >= 0 && rows[i].ec <= e && rows[i].ec > best_c) best_c = rows[i].ec;
    end
    if (best_s >= 0) begin
      end_b = lr.ec;
`ifdef WGL_TIMEOUT_EN
      if (lr.ea < 0) end_b = lr.s + TO;
      o.to = (lr.ea < 0) && (e >= lr.s + TO);
`endif
      o.busy = (end_b < 0) || (e < end_b);
      o.va   = (lr.ea >= 0) && (e >= lr.ea);
      o.vc   = (lr.ec >= 0) && (e >= lr.ec);
    end
    if (best_a >= 0) o.da = base_a[ch] + W'(best_a);
    if (best_c >= 0) o.dc = base_c[ch] + W'(best_c);
    return o;
  endfunction

  task automatic drive(input int scn, input int e);
    int r0;
    r0 = rst_tab[scn];
    start  = '0;
    enable = '0;
    if (r0 >= 0) rst = (e >= r0) && (e < r0 + 2);
    for (int ch = 0; ch < NCH; ch++) begin
      din_a[ch*W +: W] = base_a[ch] + W'(e);
      din_c[ch*W +: W] = base_c[ch] + W'(e);
    end
    for (int i = 0; i < rows.size(); i++) begin
      if (rows[i].scn != scn) continue;
      if (rows[i].ef <= e && e <= rows[i].et) enable[rows[i].ch] = 1'b1;
      if (rows[i].s == e) begin
        start[rows[i].ch] = 1'b1;
        if (!rows[i].ign) begin
          if (rows[i].ea >= 0 && !(r0 >= 0 && rows[i].s < r0 && rows[i].ea >= r0))
            sbq.push_back('{rows[i].ch, 0, rows[i].ea, base_a[rows[i].ch] + W'(rows[i].ea)});
          if (rows[i].ec >= 0 && !(r0 >= 0 && rows[i].s < r0 && rows[i].ec >= r0))
            sbq.push_back('{rows[i].ch, 1, rows[i].ec, base_c[rows[i].ch] + W'(rows[i].ec)});
        end
      end
    end
  endtask

  task automatic sb_pop(input int ch, input int kind, input int e, input logic [W-1:0] d);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (idx < 0 && sbq[i].ch == ch && sbq[i].kind == kind) idx = i;
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL sb_unexpected scn=%0d ch=%0d kind=%0d actual_edge=%0d required=none",
               cur_scn, ch, kind, e);
    end else begin
      if (sbq[idx].edge_n != e || sbq[idx].data !== d) begin
        n_bad++;
        $display("FAIL sb_capture scn=%0d ch=%0d kind=%0d actual edge=%0d data=%h required edge=%0d data=%h",
                 cur_scn, ch, kind, e, d, sbq[idx].edge_n, sbq[idx].data);
      end
      sbq.delete(idx);
    end
  endtask

  task automatic sb_observe(input int e);
    obs_t o;
    for (int ch = 0; ch < NCH; ch++) begin
      o = obs_dut(ch);
      if (o.va && !prev_va[ch]) sb_pop(ch, 0, e, o.da);
      if (o.vc && !prev_vc[ch]) sb_pop(ch, 1, e, o.dc);
      prev_va[ch] = o.va;
      prev_vc[ch] = o.vc;
    end
  endtask

  initial begin
    base_a[0] = 8'h07; base_c[0] = 8'h55;
    base_a[1] = 8'hA3; base_c[1] = 8'h3C;
    foreach (rst_tab[i]) rst_tab[i] = -1;
    //       scn ch ign  s   ef    et   ea  ec
    add_row(0, 0, 0,  0,    3,  999, 13, 23);
    add_row(0, 0, 1,  8, -100, -100, -1, -1);
    add_row(1, 1, 0,  0,   -5,  999, 11, 21);
    add_row(2, 0, 0,  0,    5,    5, 15, 25);
    add_row(3, 0, 0,  0,    3,  999, 13, 23);
    add_row(3, 0, 1,  8, -100, -100, -1, -1);
    add_row(3, 1, 0,  0,    2,  999, 12, 22);
    add_row(3, 1, 0, 14, -100, -100, 25, 35);
    rst_tab[3] = 10;
    add_row(4, 0, 0,  0,    2,  999, 12, 22);
    add_row(4, 1, 0,  4,    9,   12, 19, 29);
    add_row(5, 0, 0,  0,    0,    0, -1, -1);
    add_row(5, 1, 0,  2,    6,  999, 16, 26);
    add_row(5, 1, 0, 30, -100, -100, 41, 51);
    add_row(6, 0, 0,  0,   20,  999, 30, 40);
`ifdef WGL_TIMEOUT_EN
    add_row(7, 0, 0,  0, -100, -100, -1, -1);
    add_row(7, 0, 0, 25,   27,  999, 37, 47);
`endif

    for (int scn = 0; scn < nscn; scn++) begin
      cur_scn = scn;
      rst = 1'b1; start = '0; enable = '0; din_a = '0; din_c = '0;
      @(negedge clk);
      check("reset_state", -1, -1, all_out(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      for (int ch = 0; ch < NCH; ch++) begin prev_va[ch] = 1'b0; prev_vc[ch] = 1'b0; end
      for (int e = 0; e < RUN; e++) begin
        drive(scn, e);
        if (rst_tab[scn] == e) begin
          #1;
          check("async_reset", e, -1, all_out(), 64'd0);
        end
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++)
          check("edge_outputs", e, ch, 64'(obs_dut(ch)), 64'(exp_ch(scn, ch, e)));
        sb_observe(e);
      end
      check("sb_leftover", RUN, -1, 64'(sbq.size()), 64'd0);
      sbq.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
